// File: rtl/piano_key_scanner_if.sv
// Key/note bundle between the push-button front end and the tone generator.
// The scanner is the slave: it takes the raw keys and drives note, hush and note_strobe.
interface piano_key_scanner_if;
    logic [15:0] keys;
    logic [3:0]  note;
    logic        hush;
    logic        note_strobe;

    modport master (
        output keys,
        input  note,
        input  hush,
        input  note_strobe
    );

    modport slave (
        input  keys,
        output note,
        output hush,
        output note_strobe
    );
endinterface

// File: rtl/piano_key_scanner.sv
// Synchronises and debounces 16 push-buttons, then priority-encodes them (lowest key wins)
// into the tone generator's note code and hush control.
module piano_key_scanner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 19
) (
    input  logic              clk,
    input  logic              reset,
    piano_key_scanner_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StArm, StPlay, StRelease} state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [15:0]      sync1_q, ks_q;
    logic             cand_any_q, cand_any_d;
    logic [3:0]       cand_idx_q, cand_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       note_q, note_d;
    logic             hush_q, hush_d;
    logic             strobe_q, strobe_d;

    logic             samp_any;
    logic [3:0]       samp_idx;
    logic             samp_eq_cand;
    logic             samp_eq_note;
    logic             window_done;

    // Descending scan so the lowest pressed index is the last one written.
    always_comb begin
        samp_any = |ks_q;
        samp_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (ks_q[i]) samp_idx = 4'(i);
        end
    end

    always_comb begin
        samp_eq_cand = (samp_any == cand_any_q) && (samp_idx == cand_idx_q);
        samp_eq_note = samp_any && (samp_idx == note_q);
        window_done  = (cnt_q == CntLast);
    end

    always_comb begin
        state_d    = state_q;
        cand_any_d = cand_any_q;
        cand_idx_d = cand_idx_q;
        cnt_d      = cnt_q;
        note_d     = note_q;
        hush_d     = hush_q;
        strobe_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (samp_any) begin
                    cand_any_d = samp_any;
                    cand_idx_d = samp_idx;
                    cnt_d      = '0;
                    state_d    = StArm;
                end
            end
            StArm: begin
                if (!samp_eq_cand) begin
                    cand_any_d = samp_any;
                    cand_idx_d = samp_idx;
                    cnt_d      = '0;
                end else if (window_done) begin
                    if (cand_any_q) begin
                        note_d   = cand_idx_q;
                        hush_d   = 1'b0;
                        strobe_d = 1'b1;
                        state_d  = StPlay;
                    end else begin
                        // Press bounced away entirely: nothing was ever committed.
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StPlay: begin
                if (!samp_eq_note) begin
                    cand_any_d = samp_any;
                    cand_idx_d = samp_idx;
                    cnt_d      = '0;
                    state_d    = StRelease;
                end
            end
            StRelease: begin
                if (samp_eq_note) begin
                    cnt_d   = '0;
                    state_d = StPlay;
                end else if (!samp_eq_cand) begin
                    cand_any_d = samp_any;
                    cand_idx_d = samp_idx;
                    cnt_d      = '0;
                end else if (window_done) begin
                    if (cand_any_q) begin
                        note_d   = cand_idx_q;
                        strobe_d = (cand_idx_q != note_q);
                        state_d  = StPlay;
                    end else begin
                        hush_d   = 1'b1;
                        strobe_d = 1'b1;
                        state_d  = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            ks_q       <= '0;
            state_q    <= StIdle;
            cand_any_q <= 1'b0;
            cand_idx_q <= 4'd0;
            cnt_q      <= '0;
            note_q     <= 4'd0;
            hush_q     <= 1'b1;
            strobe_q   <= 1'b0;
        end else begin
            sync1_q    <= bus.keys;
            ks_q       <= sync1_q;
            state_q    <= state_d;
            cand_any_q <= cand_any_d;
            cand_idx_q <= cand_idx_d;
            cnt_q      <= cnt_d;
            note_q     <= note_d;
            hush_q     <= hush_d;
            strobe_q   <= strobe_d;
        end
    end

    assign bus.note        = note_q;
    assign bus.hush        = hush_q;
    assign bus.note_strobe = strobe_q;

endmodule

// File: tb/tb_piano_key_scanner.sv
// Bench for piano_key_scanner: directed scenarios plus random key traffic, checked every
// cycle against a run-length debounce model of the synchronised key samples.
module tb_piano_key_scanner;

    localparam int D = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    piano_key_scanner_if bus ();

    piano_key_scanner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int passed = 0;
    int total  = 0;
    logic chk_en = 1'b0;

    // Model: a changed sample {any,idx} is committed once it has been seen D+1 times in a row.
    logic [15:0] m_s1, m_ks;
    logic [4:0]  m_prev, m_c;
    int          m_run;
    logic [3:0]  m_note;
    logic        m_hush, m_strobe;

    function automatic logic [4:0] enc(input logic [15:0] k);
        logic [4:0] r;
        r = 5'd0;
        for (int i = 0; i < 16; i++) begin
            if (k[i] && !r[4]) r = {1'b1, 4'(i)};
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_s1 = '0; m_ks = '0; m_prev = '0; m_c = '0; m_run = 0;
        m_note = 4'd0; m_hush = 1'b1; m_strobe = 1'b0;
    endtask

    task automatic tick(input logic [15:0] k);
        logic [4:0] s;
        bus.keys = k;
        @(posedge clk);
        s = enc(m_ks);
        m_run = (s == m_prev) ? m_run + 1 : 1;
        m_prev = s;
        m_strobe = 1'b0;
        if (s != m_c && m_run >= D + 1) begin
            m_c = s;
            m_strobe = 1'b1;
            if (s[4]) begin
                m_note = s[3:0];
                m_hush = 1'b0;
            end else begin
                m_hush = 1'b1;
            end
        end
        m_ks = m_s1;
        m_s1 = k;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_hush", 16'(bus.hush), 16'd1);
        check("rst_note", 16'(bus.note), 16'd0);
        check("rst_strobe", 16'(bus.note_strobe), 16'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_note", 16'(bus.note), 16'(m_note));
            check("model_hush", 16'(bus.hush), 16'(m_hush));
            check("model_strobe", 16'(bus.note_strobe), 16'(m_strobe));
        end
    end

    initial begin
        int strobes;
        bus.keys = '0;
        do_reset();
        chk_en = 1'b1;

        // Idle stays idle with no keys
        for (int i = 0; i < 8; i++) tick(16'h0000);
        check("idle_hush", 16'(bus.hush), 16'd1);
        check("idle_note", 16'(bus.note), 16'd0);

        // Clean press of key 5: commit lands on E6
        for (int i = 0; i <= 7; i++) begin
            tick(16'h0020);
            if (i == 5) check("press_e5_hush", 16'(bus.hush), 16'd1);
            if (i == 6) begin
                check("press_e6_hush", 16'(bus.hush), 16'd0);
                check("press_e6_note", 16'(bus.note), 16'd5);
                check("press_e6_strobe", 16'(bus.note_strobe), 16'd1);
            end
            if (i == 7) check("press_e7_strobe", 16'(bus.note_strobe), 16'd0);
        end
        // Clean release
        for (int i = 0; i <= 7; i++) begin
            tick(16'h0000);
            if (i == 5) check("rel_e5_hush", 16'(bus.hush), 16'd0);
            if (i == 6) begin
                check("rel_e6_hush", 16'(bus.hush), 16'd1);
                check("rel_e6_note", 16'(bus.note), 16'd5);
            end
        end

        // Bouncing key 3, then held
        for (int i = 0; i < 20; i++) begin
            tick((i % 4 < 2) ? 16'h0008 : 16'h0000);
            check("bounce_hush", 16'(bus.hush), 16'd1);
        end
        for (int i = 0; i <= 7; i++) begin
            tick(16'h0008);
            if (i == 5) check("bounce_e5_hush", 16'(bus.hush), 16'd1);
            if (i == 6) begin
                check("bounce_e6_hush", 16'(bus.hush), 16'd0);
                check("bounce_e6_note", 16'(bus.note), 16'd3);
            end
        end

        // Move to note 7, then a 2-cycle dropout
        for (int i = 0; i < 8; i++) tick(16'h0080);
        check("n7_note", 16'(bus.note), 16'd7);
        for (int i = 0; i < 12; i++) begin
            tick(i < 2 ? 16'h0000 : 16'h0080);
            check("glitch_strobe", 16'(bus.note_strobe), 16'd0);
            check("glitch_hush", 16'(bus.hush), 16'd0);
            check("glitch_note", 16'(bus.note), 16'd7);
        end

        // Priority: keys 9 and 2, then release 2
        for (int i = 0; i < 8; i++) tick(16'h0204);
        check("prio_note2", 16'(bus.note), 16'd2);
        strobes = 0;
        for (int i = 0; i < 12; i++) begin
            tick(16'h0200);
            if (bus.note_strobe) strobes++;
            check("prio_hush", 16'(bus.hush), 16'd0);
        end
        check("prio_note9", 16'(bus.note), 16'd9);
        check("prio_strobes", 16'(strobes), 16'd1);

        // Extreme codes
        for (int i = 0; i < 10; i++) tick(16'h8000);
        check("key15_note", 16'(bus.note), 16'd15);
        for (int i = 0; i < 10; i++) tick(16'h0001);
        check("key0_note", 16'(bus.note), 16'd0);
        check("key0_hush", 16'(bus.hush), 16'd0);

        // Reset in the middle of a pending window
        for (int i = 0; i < 4; i++) tick(16'h0010);
        do_reset();
        for (int i = 0; i < 8; i++) tick(16'h0000);
        check("post_rst_hush", 16'(bus.hush), 16'd1);

        // Random traffic
        for (int p = 0; p < 300; p++) begin
            logic [15:0] k;
            int r;
            int len;
            r = $urandom_range(0, 9);
            if (r < 3) k = 16'h0000;
            else if (r < 7) k = 16'h0001 << $urandom_range(0, 15);
            else k = 16'($urandom);
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) tick(k);
            if ($urandom_range(0, 49) == 0) do_reset();
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
